layer_controller: RTL
=====================

# layer_controller

Sequencer for one fully-connected LIF layer: accepts one input spike frame, clears the layer's membrane state, and clock-enables the layer for a fixed number of timesteps. It accumulates per-neuron output spike counts, then scans them sequentially to report the winning neuron (rate-coded argmax) over a ready/valid handshake. It sits between the input spike source and the layer instance, driving the layer's `x`, `ce` and `rst_n` inputs and consuming its `spike_out`.

## Interface
- `N_IN`, 256, input frame width; matches the layer's `2**n_stage`.
- `NEURON_NUM`, 64, number of neurons in the layer.
- `N_STEPS`, 8, timesteps per inference; must be ≥1.
- `CNT_W`, derived clog2(`N_STEPS`+1), per-neuron counter width.
- `IDX_W`, derived clog2(`NEURON_NUM`), class index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input frame offered.
- `in_ready` out 1: controller accepts a frame.
- `in_x` in `N_IN`: input spike frame.
- `x_out` out `N_IN`: latched frame to layer `x`.
- `ce` out 1: layer clock enable, one-cycle pulse per timestep.
- `layer_rst_n` out 1: layer reset, active-low.
- `spike_in` in `NEURON_NUM`: layer `spike_out`.
- `out_valid` out 1: result available.
- `out_ready` in 1: result consumed.
- `out_class` out `IDX_W`: winning neuron index.
- `out_count` out `CNT_W`: winner's spike count.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, CLEAR, STEP, CAPTURE, SCAN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_x`→`x_out`, zero all counters and `step_cnt`, then go to CLEAR.
- **CLEAR**
  - `layer_rst_n`=0 for exactly this one cycle.
  - Then go to STEP.
- **STEP**
  - `ce`=1 for exactly this one cycle.
  - Then go to CAPTURE.
- **CAPTURE**
  - For each i: `cnt[i]` += `spike_in[i]`.
  - If `step_cnt`==`N_STEPS`-1: go to SCAN with `idx`=0, `best_idx`=0, `best_cnt`=0.
  - Else: increment `step_cnt` and go to STEP.
- **SCAN**
  - One neuron per cycle.
  - If `cnt[idx]` > `best_cnt` (strictly greater): `best_idx`←`idx`, `best_cnt`←`cnt[idx]`.
  - When `idx`==`NEURON_NUM`-1, go to DONE after the final compare.
- **DONE**
  - `out_valid`=1; `out_class`=`best_idx`, `out_count`=`best_cnt`.
  - On `out_ready`: go to IDLE.
- **Arithmetic:** counters cannot overflow, since the maximum count is `N_STEPS`. No saturation logic.
- **Ties:** the lowest index wins. All-zero counts give class 0, count 0.
- **Held values:**
  - `x_out` holds its value from acceptance until the next accepted frame.
  - `out_class` and `out_count` hold until the next SCAN completes.
- **Output registering:**
  - `ce` and `layer_rst_n` are registered outputs (glitch-free).
  - `layer_rst_n` is also forced low asynchronously while `rst_n`=0.
- **Input outside IDLE:** `in_valid` is ignored.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `x_out`=0, `ce`=0, `layer_rst_n`=0, `out_valid`=0, `out_class`=0, `out_count`=0, `busy`=0.
  - `layer_rst_n` rises on the first clock edge after `rst_n` deasserts.
- **Input handshake:** completes at edge E with `in_valid`&`in_ready`.
  - The CLEAR cycle follows immediately.
  - The first `ce` pulse is in cycle E+2.
- Each timestep takes 2 cycles: `ce` in STEP, and `spike_in` (the layer's registered response) is sampled in the next cycle.
- Exactly `N_STEPS` `ce` pulses per inference, spaced 2 cycles apart.
- **Latency:** `out_valid` rises 1+2·`N_STEPS`+`NEURON_NUM` cycles after E. This is 81 with the defaults.
- **Output hold:** `out_valid` stays high until `out_ready`; values are stable while stalled.
- **Throughput:** IDLE is re-entered on the cycle after the output handshake. Back-to-back throughput is one frame per 3+2·`N_STEPS`+`NEURON_NUM` cycles.
- **Reset mid-operation** (any state):
  - All outputs take their reset values immediately; `ce` drops asynchronously.
  - The partial result is discarded, and no `out_valid` is produced for the aborted frame.

## Test plan
- **Reset:** hold `rst_n`=0 mid-SCAN → `ce`=0, `layer_rst_n`=0, `out_valid`=0, `busy`=0 immediately. After release, `in_ready`=1 and `layer_rst_n`=1 after one edge.
- **Single winner** (defaults): bench drives `spike_in[5]`=1 in every CAPTURE cycle, all others 0.
  - Expect exactly 8 `ce` pulses, one `layer_rst_n` low cycle, and `x_out` equal to the frame throughout.
  - Expect `out_valid` at E+81 with `out_class`=5, `out_count`=8.
- **Tie:** neurons 9 and 3 each spike in 4 of 8 steps, neuron 60 in 3 → `out_class`=3, `out_count`=4.
- **Silence:** no spikes → `out_class`=0, `out_count`=0. Separately, only neuron 63 spikes once → `out_class`=63, `out_count`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`, and pulse `in_valid` with a new frame during busy.
  - Outputs stay stable, `in_ready`=0, and the frame is not latched.
  - After `out_ready`, the new frame is accepted on the next cycle and the second result is correct.

Source files
------------

// File: rtl/layer_controller.sv
// rtl/layer_controller.sv - sequencer for one fully-connected LIF layer with rate-coded argmax readout
//
// Purpose: accepts one input spike frame, resets the layer, clock-enables it
// for N_STEPS timesteps, accumulates per-neuron spike counts and reports the
// neuron with the highest count over a ready/valid handshake.
//
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     - input frame handshake, in_x is the frame
//   x_out                 - latched frame driven to the layer's x input
//   ce                    - layer clock enable, one pulse per timestep
//   layer_rst_n           - layer reset, low for one cycle per inference
//   spike_in              - layer spike_out, sampled the cycle after ce
//   out_valid/out_ready   - result handshake
//   out_class, out_count  - winning neuron index and its spike count
//   busy                  - high whenever an inference is in progress
module layer_controller #(
    parameter int N_IN       = 256,
    parameter int NEURON_NUM = 64,
    parameter int N_STEPS    = 8,
    parameter int CNT_W      = $clog2(N_STEPS + 1),
    parameter int IDX_W      = $clog2(NEURON_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       in_x,
    output logic [N_IN-1:0]       x_out,
    output logic                  ce,
    output logic                  layer_rst_n,
    input  logic [NEURON_NUM-1:0] spike_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_class,
    output logic [CNT_W-1:0]      out_count,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_STEP    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_SCAN    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] cnt [NEURON_NUM];
    logic [CNT_W-1:0] step_cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;

    logic             last_step;
    logic             last_idx;
    logic             cand_better;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] win_cnt;

    assign last_step   = (step_cnt == CNT_W'(N_STEPS - 1));
    assign last_idx    = (idx == IDX_W'(NEURON_NUM - 1));
    // Strict compare keeps the earliest (lowest) index on ties.
    assign cand_better = (cnt[idx] > best_cnt);
    assign win_idx     = cand_better ? idx : best_idx;
    assign win_cnt     = cand_better ? cnt[idx] : best_cnt;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (in_valid) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_STEP;
            S_STEP:    next_state = S_CAPTURE;
            S_CAPTURE: next_state = last_step ? S_SCAN : S_STEP;
            S_SCAN:    if (last_idx) next_state = S_DONE;
            S_DONE:    if (out_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ce          <= 1'b0;
            layer_rst_n <= 1'b0;
            x_out       <= '0;
            step_cnt    <= '0;
            idx         <= '0;
            best_idx    <= '0;
            best_cnt    <= '0;
            out_class   <= '0;
            out_count   <= '0;
            for (int i = 0; i < NEURON_NUM; i++) cnt[i] <= '0;
        end else begin
            state       <= next_state;
            // ce and layer_rst_n are decoded from the next state so they are
            // flop outputs that line up exactly with the STEP / CLEAR cycles.
            ce          <= (next_state == S_STEP);
            layer_rst_n <= (next_state != S_CLEAR);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_out    <= in_x;
                        step_cnt <= '0;
                        for (int i = 0; i < NEURON_NUM; i++) cnt[i] <= '0;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NEURON_NUM; i++)
                        cnt[i] <= cnt[i] + CNT_W'(spike_in[i]);
                    if (last_step) begin
                        idx      <= '0;
                        best_idx <= '0;
                        best_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                S_SCAN: begin
                    best_idx <= win_idx;
                    best_cnt <= win_cnt;
                    idx      <= idx + IDX_W'(1);
                    // Published outputs only change once a full scan finishes.
                    if (last_idx) begin
                        out_class <= win_idx;
                        out_count <= win_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
